hazard_redirect_controller: RTL and testbench

Parametrised successor to the single-source mispredict flush logic. Arbitrates `NUM_SRC` pipeline redirect requests (branch mispredict, jump, trap, …) and drives a per-stage flush vector and a single PC-redirect command to fetch. Holds a redirect pending while fetch is stalled, and keeps flushing the front stage for `FETCH_LAT` fetch cycles after a redirect, so stale instruction-memory responses are squashed. Sits in the hazard unit, between the execute/commit redirect sources and the fetch PC mux.

---
 rtl/hazard_redirect_controller.sv | 133 +++++++++++++
 tb/tb_hazard_redirect_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_redirect_controller.sv
// Hazard-unit redirect arbiter: picks the highest-priority redirect source, drives
// per-stage flush and the fetch PC redirect, holds it over fetch stalls and drains stale fetches.
module hazard_redirect_controller #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned FETCH_LAT  = 1,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           redirect_req,
    input  logic [NUM_SRC-1:0][XLEN-1:0] redirect_pc,
    input  logic                         stall_f,
    output logic [NUM_STAGES-1:0]        flush,
    output logic                         pc_redirect_valid,
    output logic [XLEN-1:0]              pc_redirect_target,
    output logic                         flag,
    output logic                         busy,
    output logic [CNT_W-1:0]             redirect_cnt
);

    localparam int unsigned        DRAIN_W    = 4;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(FETCH_LAT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic [DRAIN_W-1:0]  w_drain_nxt;
    logic [XLEN-1:0]     r_latched_pc;
    logic [XLEN-1:0]     w_latched_nxt;
    logic [CNT_W-1:0]    r_redirect_cnt;

    logic                w_req_any;
    logic                w_found;
    logic [XLEN-1:0]     w_win_pc;
    logic                w_issue;
    logic [XLEN-1:0]     w_target;
    logic [NUM_STAGES-1:0] w_flush;

    assign w_req_any = |redirect_req;

    // Fixed priority: lowest index wins.
    always_comb begin
        w_found  = 1'b0;
        w_win_pc = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (redirect_req[i] && !w_found) begin
                w_found  = 1'b1;
                w_win_pc = redirect_pc[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_drain_cnt  <= '0;
            r_latched_pc <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_cnt  <= w_drain_nxt;
            r_latched_pc <= w_latched_nxt;
        end
    end

    // Next state, issue decision and flush; a live request always beats a latched target.
    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain_cnt;
        w_latched_nxt = r_latched_pc;
        w_issue       = 1'b0;
        w_target      = r_latched_pc;
        w_flush       = '0;

        if (w_req_any && !stall_f) begin
            w_issue  = 1'b1;
            w_target = w_win_pc;
        end else if ((r_state == S_PENDING) && !stall_f) begin
            w_issue  = 1'b1;
            w_target = r_latched_pc;
        end

        if (w_req_any && stall_f) begin
            w_state_nxt   = S_PENDING;
            w_latched_nxt = w_win_pc;
        end else if (w_issue) begin
            if (DRAIN_INIT == '0) begin
                w_state_nxt = S_IDLE;
                w_drain_nxt = '0;
            end else begin
                w_state_nxt = S_DRAIN;
                w_drain_nxt = DRAIN_INIT;
            end
        end else if ((r_state == S_DRAIN) && !stall_f) begin
            if (r_drain_cnt <= DRAIN_W'(1)) begin
                w_state_nxt = S_IDLE;
                w_drain_nxt = '0;
            end else begin
                w_drain_nxt = r_drain_cnt - DRAIN_W'(1);
            end
        end

        if (w_req_any || (r_state == S_PENDING)) begin
            w_flush = '1;
        end else if (r_state == S_DRAIN) begin
            w_flush = NUM_STAGES'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_cnt <= '0;
        end else if (w_issue && (r_redirect_cnt != {CNT_W{1'b1}})) begin
            r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign flush              = reset ? '0 : w_flush;
    assign flag               = reset ? 1'b0 : (|w_flush);
    assign pc_redirect_valid  = reset ? 1'b0 : w_issue;
    assign pc_redirect_target = reset ? '0 : w_target;
    assign busy               = !reset && (r_state != S_IDLE);
    assign redirect_cnt       = r_redirect_cnt;

endmodule

// File: tb/tb_hazard_redirect_controller.sv
// Scoreboard bench for hazard_redirect_controller: three parameterisations share stimulus,
// one is selected for checking per phase.
module tb_hazard_redirect_controller;

    logic             clk;
    logic             reset;
    logic [1:0]       redirect_req;
    logic [1:0][31:0] rpc;
    logic             stall_f;

    logic [1:0]  flush_o  [3];
    logic        valid_o  [3];
    logic [31:0] tgt_o    [3];
    logic        flag_o   [3];
    logic        busy_o   [3];
    logic [15:0] cnt_a, cnt_c;
    logic [3:0]  cnt_b;

    int          sel;
    int          n_checks;
    int          n_pass;

    typedef struct {
        string       tag;
        logic [1:0]  flush;
        logic        valid;
        logic [31:0] tgt;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t ce;

    logic [1:0]  obs_flush;
    logic        obs_valid, obs_flag, obs_busy;
    logic [31:0] obs_tgt;
    logic [15:0] obs_cnt;

    hazard_redirect_controller #(.FETCH_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .redirect_req(redirect_req), .redirect_pc(rpc),
        .stall_f(stall_f), .flush(flush_o[0]), .pc_redirect_valid(valid_o[0]),
        .pc_redirect_target(tgt_o[0]), .flag(flag_o[0]), .busy(busy_o[0]),
        .redirect_cnt(cnt_a));

    hazard_redirect_controller #(.FETCH_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .redirect_req(redirect_req), .redirect_pc(rpc),
        .stall_f(stall_f), .flush(flush_o[1]), .pc_redirect_valid(valid_o[1]),
        .pc_redirect_target(tgt_o[1]), .flag(flag_o[1]), .busy(busy_o[1]),
        .redirect_cnt(cnt_b));

    hazard_redirect_controller #(.FETCH_LAT(0), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .redirect_req(redirect_req), .redirect_pc(rpc),
        .stall_f(stall_f), .flush(flush_o[2]), .pc_redirect_valid(valid_o[2]),
        .pc_redirect_target(tgt_o[2]), .flag(flag_o[2]), .busy(busy_o[2]),
        .redirect_cnt(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_flush = flush_o[0];
        obs_valid = valid_o[0];
        obs_tgt   = tgt_o[0];
        obs_flag  = flag_o[0];
        obs_busy  = busy_o[0];
        obs_cnt   = cnt_a;
        if (sel == 1) begin
            obs_flush = flush_o[1];
            obs_valid = valid_o[1];
            obs_tgt   = tgt_o[1];
            obs_flag  = flag_o[1];
            obs_busy  = busy_o[1];
            obs_cnt   = 16'(cnt_b);
        end else if (sel == 2) begin
            obs_flush = flush_o[2];
            obs_valid = valid_o[2];
            obs_tgt   = tgt_o[2];
            obs_flag  = flag_o[2];
            obs_busy  = busy_o[2];
            obs_cnt   = cnt_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Drive one cycle of stimulus and queue what the selected DUT must show in that cycle.
    task automatic step(input string tag, input logic [1:0] req, input logic [31:0] p0,
                        input logic [31:0] p1, input logic stall, input logic [1:0] ef,
                        input logic ev, input logic [31:0] et, input logic eb,
                        input logic [15:0] ec);
        exp_t e;
        redirect_req = req;
        rpc[0]       = p0;
        rpc[1]       = p1;
        stall_f      = stall;
        e.tag = tag; e.flush = ef; e.valid = ev; e.tgt = et; e.busy = eb; e.cnt = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        redirect_req = '0;
        rpc          = '0;
        stall_f      = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            ce = sb.pop_front();
            check({ce.tag, ".flush"}, 32'(obs_flush), 32'(ce.flush));
            check({ce.tag, ".flag"},  32'(obs_flag),  32'(|ce.flush));
            check({ce.tag, ".valid"}, 32'(obs_valid), 32'(ce.valid));
            check({ce.tag, ".tgt"},   obs_tgt,        ce.tgt);
            check({ce.tag, ".busy"},  32'(obs_busy),  32'(ce.busy));
            check({ce.tag, ".cnt"},   32'(obs_cnt),   32'(ce.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_pass = 0; sel = 0;
        reset = 1'b1; redirect_req = '0; rpc = '0; stall_f = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.flush", 32'(obs_flush), 32'h0);
        check("rst.valid", 32'(obs_valid), 32'h0);
        check("rst.busy",  32'(obs_busy),  32'h0);
        check("rst.cnt",   32'(obs_cnt),   32'h0);
        reset = 1'b0;

        // FETCH_LAT=1: single, priority, stalled, override
        step("single",   2'b10, 32'h0,   32'h100, 1'b0, 2'b11, 1'b1, 32'h100, 1'b0, 16'd0);
        step("single_d", 2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd1);
        step("single_i", 2'b00, 32'h0,   32'h0,   1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 16'd1);
        step("prio",     2'b11, 32'h200, 32'h300, 1'b0, 2'b11, 1'b1, 32'h200, 1'b0, 16'd1);
        step("prio_d",   2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd2);
        step("prio_i",   2'b00, 32'h0,   32'h0,   1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 16'd2);
        step("stall1",   2'b01, 32'h400, 32'h0,   1'b1, 2'b11, 1'b0, 32'h0,   1'b0, 16'd2);
        step("stall2",   2'b00, 32'h0,   32'h0,   1'b1, 2'b11, 1'b0, 32'h400, 1'b1, 16'd2);
        step("stall3",   2'b00, 32'h0,   32'h0,   1'b1, 2'b11, 1'b0, 32'h400, 1'b1, 16'd2);
        step("stall_is", 2'b00, 32'h0,   32'h0,   1'b0, 2'b11, 1'b1, 32'h400, 1'b1, 16'd2);
        step("stall_d",  2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h400, 1'b1, 16'd3);
        step("stall_i",  2'b00, 32'h0,   32'h0,   1'b0, 2'b00, 1'b0, 32'h400, 1'b0, 16'd3);
        step("ovr_pend", 2'b01, 32'h400, 32'h0,   1'b1, 2'b11, 1'b0, 32'h400, 1'b0, 16'd3);
        step("ovr_new",  2'b10, 32'h0,   32'h500, 1'b0, 2'b11, 1'b1, 32'h500, 1'b1, 16'd3);
        step("ovr_d",    2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h400, 1'b1, 16'd4);
        step("ovr_i",    2'b00, 32'h0,   32'h0,   1'b0, 2'b00, 1'b0, 32'h400, 1'b0, 16'd4);

        // FETCH_LAT=3, CNT_W=4: stall in drain, restart, reset mid-drain, saturation
        sel = 1;
        do_reset();
        step("b_iss",    2'b01, 32'hA00, 32'h0,   1'b0, 2'b11, 1'b1, 32'hA00, 1'b0, 16'd0);
        step("b_d1",     2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd1);
        step("b_ds1",    2'b00, 32'h0,   32'h0,   1'b1, 2'b01, 1'b0, 32'h0,   1'b1, 16'd1);
        step("b_ds2",    2'b00, 32'h0,   32'h0,   1'b1, 2'b01, 1'b0, 32'h0,   1'b1, 16'd1);
        step("b_d2",     2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd1);
        step("b_d3",     2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd1);
        step("b_idle",   2'b00, 32'h0,   32'h0,   1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 16'd1);
        step("b_r1",     2'b01, 32'hB00, 32'h0,   1'b0, 2'b11, 1'b1, 32'hB00, 1'b0, 16'd1);
        step("b_r1d",    2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd2);
        step("b_r2",     2'b10, 32'h0,   32'hC00, 1'b0, 2'b11, 1'b1, 32'hC00, 1'b1, 16'd2);
        step("b_r2d1",   2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd3);
        step("b_r2d2",   2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd3);
        step("b_r2d3",   2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 16'd3);
        step("b_r2i",    2'b00, 32'h0,   32'h0,   1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 16'd3);
        step("b_pend",   2'b01, 32'hD00, 32'h0,   1'b1, 2'b11, 1'b0, 32'h0,   1'b0, 16'd3);
        step("b_pis",    2'b00, 32'h0,   32'h0,   1'b0, 2'b11, 1'b1, 32'hD00, 1'b1, 16'd3);
        step("b_pd",     2'b00, 32'h0,   32'h0,   1'b0, 2'b01, 1'b0, 32'hD00, 1'b1, 16'd4);
        redirect_req = 2'b01; rpc[0] = 32'hE00; stall_f = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mrst.flush", 32'(obs_flush), 32'h0);
        check("mrst.flag",  32'(obs_flag),  32'h0);
        check("mrst.valid", 32'(obs_valid), 32'h0);
        check("mrst.tgt",   obs_tgt,        32'h0);
        check("mrst.busy",  32'(obs_busy),  32'h0);
        check("mrst.cnt",   32'(obs_cnt),   32'h0);
        redirect_req = '0; rpc = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("mrst_idle", 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat%0d", i), 2'b01, 32'(i * 4), 32'h0, 1'b0, 2'b11, 1'b1,
                 32'(i * 4), (i != 0), 16'((i > 15) ? 15 : i));
        end
        step("sat_d1",   2'b00, 32'h0, 32'h0, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 16'd15);
        step("sat_d2",   2'b00, 32'h0, 32'h0, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 16'd15);
        step("sat_d3",   2'b00, 32'h0, 32'h0, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 16'd15);
        step("sat_i",    2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 16'd15);

        // FETCH_LAT=0: straight back to idle after issue
        sel = 2;
        do_reset();
        step("c_iss",    2'b10, 32'h0,   32'hF00, 1'b0, 2'b11, 1'b1, 32'hF00, 1'b0, 16'd0);
        step("c_idle",   2'b00, 32'h0,   32'h0,   1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 16'd1);
        step("c_pend",   2'b01, 32'h123, 32'h0,   1'b1, 2'b11, 1'b0, 32'h0,   1'b0, 16'd1);
        step("c_pis",    2'b00, 32'h0,   32'h0,   1'b0, 2'b11, 1'b1, 32'h123, 1'b1, 16'd1);
        step("c_idle2",  2'b00, 32'h0,   32'h0,   1'b0, 2'b00, 1'b0, 32'h123, 1'b0, 16'd2);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
